// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the execute stage and a
// 2^ADDR_W x DATA_W data memory. One request carries a byte or a two-byte
// little-endian access; the unit walks the memory one byte per cycle and
// returns assembled load data with a one-cycle done pulse.
//
// Handshake: req is only looked at in IDLE. busy is high from the cycle after
// acceptance through the done cycle; a req seen while busy is dropped, not
// queued. done is high for exactly one cycle and rdata is valid from that
// cycle until the next load overwrites it.
module mem_access_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic                  wide,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BYTE0 = 2'd1,
        S_BYTE1 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q;
    logic                  we_q;
    logic                  wide_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [2*DATA_W-1:0]   wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic [2*DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic                  mem_write_q;
    logic [DATA_W-1:0]     mem_wdata_q;

    // Sequencer: all memory-side outputs are precomputed one edge ahead so
    // they come straight from flops during the byte cycle they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            wide_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q        <= we;
                        wide_q      <= wide;
                        addr_q      <= addr;
                        wdata_q     <= wdata;
                        busy_q      <= 1'b1;
                        mem_addr_q  <= addr;
                        mem_write_q <= we;
                        mem_wdata_q <= we ? wdata[DATA_W-1:0] : '0;
                        state_q     <= S_BYTE0;
                    end
                end
                S_BYTE0: begin
                    if (!we_q) begin
                        rdata_q[DATA_W-1:0] <= mem_rdata;
                        // A narrow load must not leak a stale upper byte.
                        if (!wide_q) rdata_q[2*DATA_W-1:DATA_W] <= '0;
                    end
                    if (wide_q) begin
                        // Address wraps naturally at the top of memory.
                        mem_addr_q  <= addr_q + ADDR_W'(1);
                        mem_write_q <= we_q;
                        mem_wdata_q <= we_q ? wdata_q[2*DATA_W-1:DATA_W] : '0;
                        state_q     <= S_BYTE1;
                    end else begin
                        mem_addr_q  <= '0;
                        mem_write_q <= 1'b0;
                        mem_wdata_q <= '0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_BYTE1: begin
                    if (!we_q) rdata_q[2*DATA_W-1:DATA_W] <= mem_rdata;
                    mem_addr_q  <= '0;
                    mem_write_q <= 1'b0;
                    mem_wdata_q <= '0;
                    done_q      <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    // req is deliberately not sampled here.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Reset gates the write strobe immediately so an aborted store cannot
    // commit on the reset edge; write data is zeroed whenever no write is issued.
    always_comb begin
        mem_write = mem_write_q & ~reset;
        mem_wdata = mem_write ? mem_wdata_q : '0;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: hosts a 256x8 data memory, drives directed and
// random transactions, and checks each one against an array-level model of
// memory contents, load results, latency and write beats.
module tb_mem_access_unit;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        req;
  logic        we;
  logic        wide;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic [7:0]  mem_addr;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  mem_access_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .wide      (wide),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // ---------------- data memory ----------------
  logic [7:0] mem [256];
  logic [7:0] init_img [256];
  logic       mem_init;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_img[i];
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [256];
  logic [15:0] last_rd;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] wr_q[$];
  int          n_checks;
  int          n_pass;
  int          done_cnt;
  int          bad_wdata;
  bit          saw55;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // Bus monitor: records committed write beats and done pulses.
  always @(negedge clock) begin
    if (mem_write) wr_q.push_back({mem_addr, mem_wdata});
    if (!mem_write && mem_wdata != 8'h00) bad_wdata++;
    if (done) done_cnt++;
    if (mem_addr == 8'h55) saw55 = 1'b1;
  end

  // ---------------- driver ----------------
  task automatic run_txn(input logic t_we, input logic t_wide, input logic [7:0] t_addr,
                         input logic [15:0] t_wdata, input bit inject);
    int         cycles;
    logic [7:0] a1;
    @(negedge clock);
    wr_q.delete();
    exp_q.delete();
    done_cnt = 0;
    saw55    = 1'b0;
    req   = 1'b1;
    we    = t_we;
    wide  = t_wide;
    addr  = t_addr;
    wdata = t_wdata;
    @(posedge clock);
    #1;
    req   = 1'b0;
    we    = 1'($urandom_range(0, 1));
    wide  = 1'($urandom_range(0, 1));
    addr  = 8'($urandom_range(0, 255));
    wdata = 16'($urandom_range(0, 65535));

    // Model: byte-addressed little-endian access with 8-bit address wrap.
    a1 = t_addr + 8'd1;
    if (t_we) begin
      exp_q.push_back({t_addr, t_wdata[7:0]});
      ref_mem[t_addr] = t_wdata[7:0];
      if (t_wide) begin
        exp_q.push_back({a1, t_wdata[15:8]});
        ref_mem[a1] = t_wdata[15:8];
      end
    end else begin
      last_rd = t_wide ? {ref_mem[a1], ref_mem[t_addr]} : {8'h00, ref_mem[t_addr]};
    end

    cycles = 0;
    while (cycles < 10) begin
      @(negedge clock);
      cycles++;
      req = inject && (cycles == 2 || cycles == 3);
      if (req) addr = 8'h55;
      if (done) break;
    end
    check("done_latency", cycles, t_wide ? 3 : 2);
    check("busy_in_done", busy, 1);
    check("rdata", rdata, last_rd);

    @(negedge clock);
    req = 1'b0;
    #1;
    check("done_count", done_cnt, 1);
    check("done_low_after", done, 0);
    check("busy_low_after", busy, 0);
    check("wr_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check("wr_beat", wr_q[i], exp_q[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] keep41;
    n_checks  = 0;
    n_pass    = 0;
    bad_wdata = 0;
    done_cnt  = 0;
    reset = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    wide  = 1'b0;
    addr  = 8'h00;
    wdata = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      init_img[i] = 8'($urandom_range(0, 255));
      ref_mem[i]  = init_img[i];
    end
    last_rd  = 16'h0000;
    mem_init = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    mem_init = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;

    // Narrow store then load.
    run_txn(1'b1, 1'b0, 8'h10, 16'h00A5, 1'b0);
    check("nstore_mem10", mem[8'h10], 8'hA5);
    check("nstore_keeps_rdata", rdata, 16'h0000);
    run_txn(1'b0, 1'b0, 8'h10, 16'h0000, 1'b0);
    check("nload_val", rdata, 16'h00A5);

    // Wide store / load.
    run_txn(1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b0);
    check("wstore_mem20", mem[8'h20], 8'hEF);
    check("wstore_mem21", mem[8'h21], 8'hBE);
    run_txn(1'b0, 1'b1, 8'h20, 16'h0000, 1'b0);
    check("wload_val", rdata, 16'hBEEF);

    // Wrap-around at the top of memory.
    run_txn(1'b1, 1'b1, 8'hFF, 16'h1234, 1'b0);
    check("wrap_memFF", mem[8'hFF], 8'h34);
    check("wrap_mem00", mem[8'h00], 8'h12);
    run_txn(1'b0, 1'b1, 8'hFF, 16'h0000, 1'b0);
    check("wrap_load", rdata, 16'h1234);

    // Busy rejection: req with addr 0x55 during BYTE1 and DONE is ignored.
    run_txn(1'b0, 1'b1, 8'h20, 16'h0000, 1'b1);
    check("rej_rdata", rdata, 16'hBEEF);
    repeat (4) @(negedge clock);
    #1;
    check("rej_single_done", done_cnt, 1);
    check("rej_idle", busy, 0);
    check("rej_no_55", saw55, 0);

    // Narrow load after wide load zeroes the upper byte.
    run_txn(1'b0, 1'b0, 8'h21, 16'h0000, 1'b0);
    check("narrow_after_wide", rdata, 16'h00BE);

    // Reset in BYTE1 of a wide store.
    keep41 = mem[8'h41];
    done_cnt = 0;
    @(negedge clock);
    req = 1'b1; we = 1'b1; wide = 1'b1; addr = 8'h40; wdata = 16'h7788;
    @(posedge clock);
    #1;
    req = 1'b0;
    @(negedge clock);
    check("rst_op_byte0_write", mem_write, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_op_write_gated", mem_write, 0);
    @(posedge clock);
    #1;
    check("rst_op_busy", busy, 0);
    check("rst_op_done", done, 0);
    check("rst_op_rdata", rdata, 0);
    check("rst_op_mem_addr", mem_addr, 0);
    check("rst_op_mem_wdata", mem_wdata, 0);
    @(negedge clock);
    reset = 1'b0;
    ref_mem[8'h40] = 8'h88;
    last_rd = 16'h0000;
    check("rst_op_mem40", mem[8'h40], 8'h88);
    check("rst_op_mem41", mem[8'h41], keep41);
    check("rst_op_no_done", done_cnt, 0);

    // Random transactions against the model.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
              16'($urandom_range(0, 65535)), 1'b0);
    end

    for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_mem[i]);
    check("wdata_zero_when_idle", bad_wdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the core's execute stage and the 256x8 data memory.
- Accepts one byte or two-byte (little-endian) load/store request over a req/done handshake.
- Issues the per-byte memory cycles to the data memory and returns assembled load data.
- The data memory has combinational read and a write that commits on the clock edge; this block drives its addr/write/data-in and samples its data-out.

Parameters:
- ADDR_W, 8, address width; memory depth is 2^ADDR_W bytes.
- DATA_W, 8, memory byte width; the wide access is 2*DATA_W bits.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; latched with req.
- wide  in  1  1 = two-byte access, 0 = single byte; latched with req.
- addr  in  ADDR_W  base byte address; latched with req.
- wdata  in  2*DATA_W  store data; [7:0] goes to addr, [15:8] goes to addr+1; latched with req.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  2*DATA_W  load result; registered, valid from the done cycle.
- mem_addr  out  ADDR_W  address to the data memory.
- mem_write  out  1  write enable to the data memory.
- mem_wdata  out  DATA_W  write data to the data memory.
- mem_rdata  in  DATA_W  combinational read data from the data memory.

Behaviour:
- States: IDLE, BYTE0, BYTE1, DONE; state is registered.
- Reset values: state=IDLE, busy=0, done=0, rdata=0, mem_write=0, mem_addr=0, mem_wdata=0, all latched request fields=0.
- IDLE:
  - If req=1 at a posedge, latch we/wide/addr/wdata and go to BYTE0.
  - Otherwise remain in IDLE.
  - mem_write=0 and mem_addr=0 while IDLE.
- BYTE0:
  - mem_addr = addr_q.
  - Store: mem_write=1, mem_wdata=wdata_q[7:0].
  - Load: mem_write=0; at the exit edge, rdata[7:0] <= mem_rdata. If wide_q=0, rdata[15:8] <= 0 at the same edge.
  - Next state is BYTE1 if wide_q=1, else DONE.
- BYTE1:
  - mem_addr = addr_q + 1, modulo 2^ADDR_W (0xFF wraps to 0x00).
  - Store: mem_write=1, mem_wdata=wdata_q[15:8].
  - Load: rdata[15:8] <= mem_rdata at the exit edge.
  - Next state is DONE.
- DONE:
  - done=1, mem_write=0; go to IDLE.
  - req is ignored in DONE; the earliest next acceptance is the following cycle, in IDLE.
- Latency, counting req sampled at edge E:
  - Narrow: done is high in the cycle after edge E+1.
  - Wide: done is high in the cycle after edge E+2.
  - Narrow accepted-to-accepted throughput: 3 cycles. Wide: 4 cycles.
- req while busy=1 is ignored and not queued; the requester must hold or re-issue req after done.
- Store does not modify rdata. rdata holds its last load value until the next load's BYTE0 exit edge.
- mem_wdata=0 whenever mem_write=0.
- mem_write is combinationally gated by !reset, so no memory write commits on an edge where reset=1.
- Reset mid-operation aborts the transaction and returns to IDLE with no done pulse. For a wide store reset in BYTE1, byte 0 stays written and byte 1 is not written.
- Inputs change freely while busy; only the latched copies are used.

Test Plan:
- Narrow store then load: req we=1 wide=0 addr=0x10 wdata=0x00A5; then load addr=0x10 -> one mem_write pulse at 0x10 with data 0xA5; load done 2 cycles after accept with rdata=0x00A5.
- Wide store/load: store addr=0x20 wdata=0xBEEF -> mem[0x20]=0xEF, mem[0x21]=0xBE; wide load addr=0x20 -> rdata=0xBEEF, done 3 cycles after accept.
- Wrap-around: wide store addr=0xFF wdata=0x1234 -> mem[0xFF]=0x34, mem[0x00]=0x12; wide load addr=0xFF -> rdata=0x1234.
- Busy rejection: issue a wide load, then pulse req with addr=0x55 during BYTE1 -> second request ignored; exactly one done pulse; mem_addr never equals 0x55.
- Reset mid-op: wide store addr=0x40 wdata=0x7788 with reset asserted in BYTE1 -> mem[0x40]=0x88, mem[0x41] unchanged; no done pulse; all outputs at reset values next cycle.
- Narrow load after wide load: wide load returning 0xBEEF, then narrow load addr=0x21 -> rdata=0x00BE (upper byte zeroed).
